display_writer: RTL and testbench

Character-stream writer for the debug screen's display memory. Accepts ASCII bytes over a valid/ready handshake, tracks a text cursor on the 80×32 character grid, and drives the display memory's write port. It handles LF, CR, BS and FF control codes, clears each new line as the cursor enters it, and wraps from the bottom row to the top. It sits between the debug text source (CPU/UART bridge) and the display memory read by the pixel pipeline.

---
 rtl/display_pkg.sv | 27 ++
 rtl/disp_cursor.sv | 77 +++++++
 rtl/display_writer.sv | 156 +++++++++++++++
 tb/tb_display_writer.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared constants and types for the debug-screen character writer.
// Grid geometry, ASCII control codes and the writer FSM state encoding.
package display_pkg;

  localparam int COLS   = 80;
  localparam int ROWS   = 32;
  localparam int ADDR_W = 12;
  localparam int X_W    = 7;
  localparam int Y_W    = 5;

  localparam logic [7:0] SPACE = 8'h20;
  localparam logic [7:0] LF    = 8'h0A;
  localparam logic [7:0] CR    = 8'h0D;
  localparam logic [7:0] BS    = 8'h08;
  localparam logic [7:0] FF    = 8'h0C;

  typedef enum logic [1:0] {
    CLR_ALL  = 2'd0,
    IDLE     = 2'd1,
    CLR_LINE = 2'd2
  } disp_wr_state_t;

  function automatic logic is_printable(input logic [7:0] c);
    return (c >= 8'h20) && (c <= 8'h7E);
  endfunction

endpackage

// File: rtl/disp_cursor.sv
// Text cursor for the character grid: column, row and the row's base address.
// Flags a line feed for explicit newlines and for advancing past the last column.
module disp_cursor #(
  parameter int COLS   = display_pkg::COLS,
  parameter int ROWS   = display_pkg::ROWS,
  parameter int ADDR_W = display_pkg::ADDR_W
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       home,
  input  logic                       advance,
  input  logic                       nl_cmd,
  input  logic                       ret,
  input  logic                       backspace,
  output logic                       line_feed,
  output logic [display_pkg::X_W-1:0] cur_x,
  output logic [display_pkg::Y_W-1:0] cur_y,
  output logic [ADDR_W-1:0]          row_base
);
  import display_pkg::*;

  localparam logic [X_W-1:0]    X_LAST   = X_W'(COLS - 1);
  localparam logic [Y_W-1:0]    Y_LAST   = Y_W'(ROWS - 1);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(COLS);

  logic [X_W-1:0]    cur_x_q, cur_x_d;
  logic [Y_W-1:0]    cur_y_q, cur_y_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d;

  assign line_feed = nl_cmd | (advance & (cur_x_q == X_LAST));

  // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (which would infer a latch).
  always_comb begin
    cur_x_d    = cur_x_q;
    cur_y_d    = cur_y_q;
    row_base_d = row_base_q;
    if (home) begin
      cur_x_d    = '0;
      cur_y_d    = '0;
      row_base_d = '0;
    end else if (line_feed) begin
      cur_x_d = '0;
      // Wrap bottom row to top; row_base tracks row*COLS without a multiplier.
      if (cur_y_q == Y_LAST) begin
        cur_y_d    = '0;
        row_base_d = '0;
      end else begin
        cur_y_d    = cur_y_q + Y_W'(1);
        row_base_d = row_base_q + ROW_STEP;
      end
    end else if (ret) begin
      cur_x_d = '0;
    end else if (backspace) begin
      if (cur_x_q != '0) cur_x_d = cur_x_q - X_W'(1);
    end else if (advance) begin
      cur_x_d = cur_x_q + X_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cur_x_q    <= '0;
      cur_y_q    <= '0;
      row_base_q <= '0;
    end else begin
      cur_x_q    <= cur_x_d;
      cur_y_q    <= cur_y_d;
      row_base_q <= row_base_d;
    end
  end

  assign cur_x    = cur_x_q;
  assign cur_y    = cur_y_q;
  assign row_base = row_base_q;

endmodule

// File: rtl/display_writer.sv
// Character-stream writer: accepts ASCII bytes, handles control codes and
// drives the display memory write port, clearing lines/screen as needed.
module display_writer #(
  parameter int COLS   = display_pkg::COLS,
  parameter int ROWS   = display_pkg::ROWS,
  parameter int ADDR_W = display_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              char_valid,
  input  logic [7:0]        char_data,
  output logic              char_ready,
  input  logic              clr_req,
  output logic              busy,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic [6:0]        cur_x,
  output logic [4:0]        cur_y
);
  import display_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(COLS * ROWS - 1);
  localparam logic [ADDR_W-1:0] LAST_COL  = ADDR_W'(COLS - 1);

  disp_wr_state_t    state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;

  logic              accept, clr_start;
  logic              cmd_home, cmd_adv, cmd_nl, cmd_ret, cmd_bs;
  logic              line_feed;
  logic [X_W-1:0]    cx;
  logic [Y_W-1:0]    cy;
  logic [ADDR_W-1:0] row_base;

  assign char_ready = (state_q == IDLE) & ~clr_req;
  assign busy       = (state_q != IDLE);
  assign accept     = char_valid & char_ready;

  // Command decode kept apart from the next-state logic so the cursor's
  // wrap flag never loops back into its own inputs.
  always_comb begin
    cmd_adv   = 1'b0;
    cmd_nl    = 1'b0;
    cmd_ret   = 1'b0;
    cmd_bs    = 1'b0;
    clr_start = clr_req & (state_q != CLR_ALL);
    if (accept) begin
      case (char_data)
        LF:      cmd_nl    = 1'b1;
        CR:      cmd_ret   = 1'b1;
        BS:      cmd_bs    = 1'b1;
        FF:      clr_start = 1'b1;
        default: cmd_adv   = is_printable(char_data);
      endcase
    end
    cmd_home = clr_start;
  end

  disp_cursor #(
    .COLS   (COLS),
    .ROWS   (ROWS),
    .ADDR_W (ADDR_W)
  ) u_cursor (
    .clk       (clk),
    .resetn    (resetn),
    .home      (cmd_home),
    .advance   (cmd_adv),
    .nl_cmd    (cmd_nl),
    .ret       (cmd_ret),
    .backspace (cmd_bs),
    .line_feed (line_feed),
    .cur_x     (cx),
    .cur_y     (cy),
    .row_base  (row_base)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (clr_start) begin
      state_d = CLR_ALL;
      cnt_d   = '0;
    end else begin
      case (state_q)
        CLR_ALL: begin
          mem_we_d    = 1'b1;
          mem_addr_d  = cnt_q;
          mem_wdata_d = SPACE;
          if (cnt_q == LAST_CELL) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + ADDR_W'(1);
          end
        end
        CLR_LINE: begin
          mem_we_d    = 1'b1;
          mem_addr_d  = row_base + cnt_q;
          mem_wdata_d = SPACE;
          if (cnt_q == LAST_COL) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + ADDR_W'(1);
          end
        end
        IDLE: begin
          if (cmd_adv) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = row_base + ADDR_W'(cx);
            mem_wdata_d = char_data;
          end
          // row_base updates at the same edge, so CLR_LINE sees the new row.
          if (line_feed) begin
            state_d = CLR_LINE;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = CLR_ALL;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= CLR_ALL;
      cnt_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= SPACE;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cur_x     = cx;
  assign cur_y     = cy;

endmodule

// File: tb/tb_display_writer.sv
// Directed bench for display_writer: vector table for single-byte behaviour,
// hand-written sequences for screen/line clears, wrap, clr_req and reset.
module tb_display_writer;

  localparam int COLS  = 80;
  localparam int ROWS  = 32;
  localparam int CELLS = COLS * ROWS;

  logic        clk = 1'b0;
  logic        resetn;
  logic        char_valid;
  logic [7:0]  char_data;
  logic        char_ready;
  logic        clr_req;
  logic        busy;
  logic        mem_we;
  logic [11:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [6:0]  cur_x;
  logic [4:0]  cur_y;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  display_writer dut (
    .clk        (clk),
    .resetn     (resetn),
    .char_valid (char_valid),
    .char_data  (char_data),
    .char_ready (char_ready),
    .clr_req    (clr_req),
    .busy       (busy),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .cur_x      (cur_x),
    .cur_y      (cur_y)
  );

  typedef struct {
    logic [7:0]  data;
    logic        exp_we;
    logic [11:0] exp_addr;
    logic [7:0]  exp_wdata;
    logic [6:0]  exp_x;
    logic [4:0]  exp_y;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] c);
    char_valid = 1'b1;
    char_data  = c;
    step();
    char_valid = 1'b0;
  endtask

  // Expect a full-screen clear starting on the next edge.
  task automatic run_clear_all(input string tag);
    int errs = 0;
    int early = 0;
    for (int i = 0; i < CELLS; i++) begin
      step();
      if (!(mem_we && mem_addr == 12'(i) && mem_wdata == 8'h20)) errs++;
      if (i < CELLS - 1 && (char_ready || !busy)) early++;
    end
    check({tag, "_seq_errs"}, errs, 0);
    check({tag, "_ready_early"}, early, 0);
    check({tag, "_ready_after"}, char_ready, 1'b1);
    check({tag, "_busy_after"}, busy, 1'b0);
    step();
    check({tag, "_we_done"}, mem_we, 1'b0);
    check({tag, "_cursor"}, {cur_y, cur_x}, 12'h000);
  endtask

  // Called right after the accept that caused a newline.
  task automatic newline_clear(input string tag, input int base, input int exp_y);
    int errs = 0;
    int low = 0;
    for (int i = 0; i < COLS; i++) begin
      if (!char_ready) low++;
      step();
      if (!(mem_we && mem_addr == 12'(base + i) && mem_wdata == 8'h20)) errs++;
    end
    check({tag, "_clr_errs"}, errs, 0);
    check({tag, "_ready_low"}, low, COLS);
    check({tag, "_ready_back"}, char_ready, 1'b1);
    check({tag, "_cursor"}, {cur_y, cur_x}, {5'(exp_y), 7'd0});
  endtask

  vec_t vecs[16];

  initial begin
    vecs[0]  = '{8'h41, 1'b1, 12'd0, 8'h41, 7'd1, 5'd0};
    vecs[1]  = '{8'h42, 1'b1, 12'd1, 8'h42, 7'd2, 5'd0};
    vecs[2]  = '{8'h08, 1'b0, 12'd0, 8'h00, 7'd1, 5'd0};
    vecs[3]  = '{8'h07, 1'b0, 12'd0, 8'h00, 7'd1, 5'd0};
    vecs[4]  = '{8'h43, 1'b1, 12'd1, 8'h43, 7'd2, 5'd0};
    vecs[5]  = '{8'h0D, 1'b0, 12'd0, 8'h00, 7'd0, 5'd0};
    vecs[6]  = '{8'h08, 1'b0, 12'd0, 8'h00, 7'd0, 5'd0};
    vecs[7]  = '{8'h7E, 1'b1, 12'd0, 8'h7E, 7'd1, 5'd0};
    vecs[8]  = '{8'h20, 1'b1, 12'd1, 8'h20, 7'd2, 5'd0};
    vecs[9]  = '{8'h7F, 1'b0, 12'd0, 8'h00, 7'd2, 5'd0};
    vecs[10] = '{8'h1F, 1'b0, 12'd0, 8'h00, 7'd2, 5'd0};
    vecs[11] = '{8'h80, 1'b0, 12'd0, 8'h00, 7'd2, 5'd0};
    vecs[12] = '{8'h61, 1'b1, 12'd2, 8'h61, 7'd3, 5'd0};
    vecs[13] = '{8'h62, 1'b1, 12'd3, 8'h62, 7'd4, 5'd0};
    vecs[14] = '{8'h63, 1'b1, 12'd4, 8'h63, 7'd5, 5'd0};
    vecs[15] = '{8'h08, 1'b0, 12'd0, 8'h00, 7'd4, 5'd0};

    resetn     = 1'b0;
    char_valid = 1'b0;
    char_data  = 8'h00;
    clr_req    = 1'b0;
    step();
    step();
    check("rst_we", mem_we, 1'b0);
    check("rst_addr", mem_addr, 12'd0);
    check("rst_wdata", mem_wdata, 8'h20);
    check("rst_cursor", {cur_y, cur_x}, 12'h000);
    check("rst_busy", busy, 1'b1);
    check("rst_ready", char_ready, 1'b0);
    resetn = 1'b1;
    run_clear_all("boot");

    // Single-byte vectors, applied back-to-back.
    for (int i = 0; i < 16; i++) begin
      check($sformatf("vec%0d_ready", i), char_ready, 1'b1);
      send_byte(vecs[i].data);
      check($sformatf("vec%0d_we", i), mem_we, vecs[i].exp_we);
      if (vecs[i].exp_we) begin
        check($sformatf("vec%0d_addr", i), mem_addr, vecs[i].exp_addr);
        check($sformatf("vec%0d_wdata", i), mem_wdata, vecs[i].exp_wdata);
      end
      check($sformatf("vec%0d_cursor", i), {cur_y, cur_x}, {vecs[i].exp_y, vecs[i].exp_x});
    end

    // Fill row 0 completely; the 80th byte wraps into row 1.
    send_byte(8'h0D);
    begin
      int errs = 0;
      int stall = 0;
      for (int i = 0; i < COLS; i++) begin
        logic [7:0] c;
        c = 8'h41 + 8'(i % 26);
        if (!char_ready) stall++;
        send_byte(c);
        if (!(mem_we && mem_addr == 12'(i) && mem_wdata == c)) errs++;
      end
      check("row0_fill_errs", errs, 0);
      check("row0_fill_stall", stall, 0);
      check("row0_last_addr", mem_addr, 12'd79);
    end
    newline_clear("wrap", COLS, 1);

    // Walk down to the bottom row with LFs, then wrap to the top.
    for (int r = 2; r < ROWS; r++) begin
      send_byte(8'h0A);
      newline_clear($sformatf("lf%0d", r), r * COLS, r);
    end
    check("bottom_row", cur_y, 5'd31);
    send_byte(8'h0A);
    newline_clear("lf_wrap", 0, 0);

    for (int i = 0; i < 10; i++) send_byte(8'h78);
    check("cr_pre_x", cur_x, 7'd10);
    send_byte(8'h0D);
    check("cr_x", cur_x, 7'd0);
    check("cr_we", mem_we, 1'b0);

    // clr_req wins over a byte presented in the same IDLE cycle.
    send_byte(8'h5A);
    char_valid = 1'b1;
    char_data  = 8'h41;
    clr_req    = 1'b1;
    #1;
    check("clr_ready_low", char_ready, 1'b0);
    step();
    char_valid = 1'b0;
    clr_req    = 1'b0;
    check("clr_no_write", mem_we, 1'b0);
    check("clr_busy", busy, 1'b1);
    check("clr_home", {cur_y, cur_x}, 12'h000);
    run_clear_all("clr");

    // Reset in the middle of a line clear.
    send_byte(8'h0A);
    for (int i = 0; i < 5; i++) step();
    check("mid_line_we", mem_we, 1'b1);
    resetn = 1'b0;
    step();
    check("mid_rst_we", mem_we, 1'b0);
    check("mid_rst_cursor", {cur_y, cur_x}, 12'h000);
    check("mid_rst_busy", busy, 1'b1);
    resetn = 1'b1;
    run_clear_all("rst");

    // FF byte behaves like clr_req.
    send_byte(8'h41);
    send_byte(8'h0C);
    check("ff_no_write", mem_we, 1'b0);
    check("ff_busy", busy, 1'b1);
    check("ff_home", cur_x, 7'd0);
    run_clear_all("ff");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
